penalty_box_drain: RTL and testbench
====================================

# penalty_box_drain

Receiving end of the penalty-box delay path. Supplies the enable that advances the 72-bit latch chain and tracks which chain stages hold real codewords, since the chain carries no valid bit. Captures each codeword as it leaves the chain and checks its per-byte parity. Buffers results in a small FIFO and presents them to the consumer over a ready/valid handshake, stalling the chain when the FIFO is full.

## Interface
Parameters:
- `LENGTH`, default 8: number of stages in the driven latch chain; must be ≥1.
- `FIFO_DEPTH`, default 4: output buffer entries; power of two, ≥2.

Ports:
- `clk`, input, 1: single clock. It also clocks the chain, which is gated by `chain_en`.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: codeword being presented at the chain input this cycle is real.
- `chain_en`, output, 1: advance enable for the chain; doubles as `in_ready` to the chain's producer.
- `chain_out`, input, 72: chain exit word. Bits [63:0] are data; bit 64+k is the even parity of data byte k (bits 8k+7:8k).
- `out_valid`, output, 1: head of FIFO valid.
- `out_ready`, input, 1: consumer accepts head.
- `out_data`, output, 64: head data.
- `out_err`, output, 8: head per-byte parity-error mask.
- `err_count`, output, 16: saturating count of codewords with a nonzero error mask.

## Operation
- `chain_en = (fifo_count < FIFO_DEPTH)`. It is registered-state only, with no combinational path from `out_ready`.
- Shadow valid shift register `vsr[LENGTH-1:0]` advances only on edges where `chain_en`=1:
  - `vsr[0] <= in_valid`;
  - `vsr[i] <= vsr[i-1]`.
- An input word is taken only on a `chain_en`=1 edge. The producer holds `in_valid` and data while `chain_en`=0.
- Exit valid is `vsr[LENGTH-1]`. Push happens on an edge where `chain_en`=1 and exit valid=1. The pushed entry is `{chain_out[63:0], err}`.
- Error mask: `err[k] = ^{chain_out[8k+7:8k], chain_out[64+k]}`, so 1 means the byte's parity failed.
- Pop happens on an edge where `out_valid`=1 and `out_ready`=1.
- FIFO count update:
  - `count + push - pop`;
  - simultaneous push and pop at full cannot occur, because push requires `chain_en`, i.e. not full;
  - simultaneous push and pop at any other count leaves the count unchanged.
- Read and write pointers are log2(`FIFO_DEPTH`) bits and wrap naturally modulo `FIFO_DEPTH`.
- `err_count` increments by 1 on every push with `err` ≠ 0 and saturates at 16'hFFFF.
- A pushed word with errors is still delivered, with its mask on `out_err`.

## Timing
- Reset values:
  - `vsr`=0, FIFO count=0, pointers=0;
  - `out_valid`=0, `out_data`=0, `out_err`=0, `err_count`=0;
  - `chain_en`=1 once `rst_n` deasserts.
- Reset mid-operation drops all in-flight and buffered words. Chain contents persist but are ignored, because `vsr` is cleared.
- Latency, input to output:
  - a word accepted at enabled edge E reaches the chain exit after `LENGTH` enabled edges;
  - it is pushed on enabled edge E+`LENGTH`;
  - `out_valid` rises the cycle after the push. With no stalls this is `LENGTH`+1 cycles.
- FIFO output is first-word-fall-through registered storage: `out_data` and `out_err` are valid whenever `out_valid`=1, and are stable while `out_ready`=0.
- The full condition takes effect in the same cycle: `chain_en` falls in the cycle after the push that fills the FIFO.
- A pop from full re-raises `chain_en` on the next cycle.
- Throughput is 1 word per cycle when `out_ready` is held at 1.

## Configuration
- `PBOX_PARITY_CHECK_EN` defined:
  - parity check, `out_err` storage and `err_count` are present as described.
- `PBOX_PARITY_CHECK_EN` undefined:
  - no parity logic;
  - FIFO entries are 64 bits;
  - `out_err` is tied to 0 and `err_count` is tied to 0;
  - all other timing is identical.

## Test plan
- Reset and fill:
  - stimulus: reset; `LENGTH`=8; feed one valid word 64'h0123_4567_89AB_CDEF with correct parity; `out_ready`=1;
  - required: `out_valid` rises exactly 9 cycles after acceptance; `out_data` matches; `out_err`=0; `err_count`=0.
- Parity error:
  - stimulus: send a word with bit 64 (byte 0 parity) inverted, and another with data bit 63 inverted;
  - required: `out_err`=8'h01, then `out_err`=8'h80; `err_count`=2.
- Backpressure:
  - stimulus: `out_ready`=0; stream 20 valid words;
  - required: exactly `FIFO_DEPTH`=4 words buffered; `chain_en`=0 afterwards; no word lost or duplicated after `out_ready` returns to 1; order preserved.
- Bubbles:
  - stimulus: alternate `in_valid`=1/0 for 10 cycles;
  - required: 5 outputs with no spurious `out_valid`; in-order data.
- Saturation:
  - stimulus: force `err_count` to 16'hFFFE; push 3 bad words;
  - required: `err_count` ends at 16'hFFFF.
- Reset mid-stream:
  - stimulus: assert `rst_n`=0 with 3 words in flight and 2 buffered;
  - required: `out_valid` drops immediately; no old words appear after release; the next new word arrives with normal latency.

Source files
------------

// File: rtl/penalty_box_drain.sv
// Drain end of the penalty-box delay path: drives the chain enable, tracks valid stages,
// buffers exiting codewords in a FWFT FIFO. Optional parity checking under PBOX_PARITY_CHECK_EN.
module penalty_box_drain #(
    parameter int LENGTH     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        chain_en,
    input  logic [71:0] chain_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [7:0]  out_err,
    output logic [15:0] err_count
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Handshakes: a word enters the chain on an edge with in_valid=1 and chain_en=1;
    // a FIFO entry leaves on an edge with out_valid=1 and out_ready=1.
    logic [LENGTH-1:0] vsr;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [63:0]       data_mem [FIFO_DEPTH];
    logic              push;
    logic              pop;

    // Enable depends only on the registered count, never on out_ready.
    assign chain_en  = (count < CW'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign push      = chain_en & vsr[LENGTH-1];
    assign pop       = out_valid & out_ready;
    assign out_data  = data_mem[rd_ptr];

    // The chain carries no valid bit, so its occupancy is shadowed here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsr <= '0;
        end else if (chain_en) begin
            vsr[0] <= in_valid;
            for (int i = 1; i < LENGTH; i++) begin
                vsr[i] <= vsr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= chain_out[63:0];
        end
    end

`ifdef PBOX_PARITY_CHECK_EN
    logic [7:0]  err;
    logic [7:0]  err_mem [FIFO_DEPTH];
    logic [15:0] err_cnt;

    // A set bit means the byte together with its even-parity bit has odd weight.
    always_comb begin
        err = '0;
        for (int k = 0; k < 8; k++) begin
            err[k] = ^{chain_out[8*k +: 8], chain_out[64+k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                err_mem[i] <= '0;
            end
            err_cnt <= '0;
        end else if (push) begin
            err_mem[wr_ptr] <= err;
            if ((err != '0) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    assign out_err   = err_mem[rd_ptr];
    assign err_count = err_cnt;
`else
    logic unused_parity;

    assign unused_parity = ^chain_out[71:64];
    assign out_err       = '0;
    assign err_count     = '0;
`endif

endmodule

// File: tb/tb_penalty_box_drain.sv
// Bench for penalty_box_drain: models the 72-bit latch chain and scoreboards exiting words.
module tb_penalty_box_drain;

    localparam int TB_LENGTH = 8;
    localparam int TB_DEPTH  = 4;
`ifdef PBOX_PARITY_CHECK_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        chain_en;
    logic [71:0] chain_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_err;
    logic [15:0] err_count;
    logic [71:0] in_word;
    logic [71:0] chain [TB_LENGTH];

    logic [71:0] exp_q[$];
    int errors   = 0;
    int checks   = 0;
    int accepted = 0;
    int rx_count = 0;
    bit stream_done;

    penalty_box_drain #(.LENGTH(TB_LENGTH), .FIFO_DEPTH(TB_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .chain_en  (chain_en),
        .chain_out (chain_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_count (err_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout, need completion");
        $fatal(1);
    end

    // Model of the external latch chain, advanced by chain_en.
    always @(posedge clk) begin
        if (chain_en) begin
            chain[0] <= in_word;
            for (int i = 1; i < TB_LENGTH; i++) chain[i] <= chain[i-1];
        end
    end
    assign chain_out = chain[TB_LENGTH-1];

    // scoreboard monitor
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            logic [71:0] e;
            rx_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_out: got data=%h err=%h, need no output", out_data, out_err);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_err} !== e) begin
                    errors++;
                    $display("FAIL out_word: got data=%h err=%h, need data=%h err=%h",
                             out_data, out_err, e[71:8], e[7:0]);
                end
            end
        end
    end

    function automatic logic [71:0] make_cw(input logic [63:0] d);
        logic [7:0] p;
        for (int k = 0; k < 8; k++) p[k] = ^d[8*k +: 8];
        return {p, d};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, got, need);
        end
    endtask

    // driver tasks
    task automatic send(input logic [63:0] d, input logic [71:0] flip, input logic [7:0] eerr);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = make_cw(d) ^ flip;
        while (!chain_en && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!chain_en) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got chain_en=0 for %0d cycles, need acceptance", n);
        end else begin
            @(posedge clk);
            exp_q.push_back({d ^ flip[63:0], PAR_ON ? eerr : 8'h00});
            accepted++;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_latency(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n++;
        end while (!out_valid && n < 40);
        check(name, 64'(n), 64'(TB_LENGTH + 1));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b1;
        stream_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_chain_en", 64'(chain_en), 64'd1);

        // Reset and fill: single good word, latency LENGTH+1
        send(64'h0123_4567_89AB_CDEF, 72'h0, 8'h00);
        check_latency("fill_latency");
        drain("fill_drain");
        check("fill_err_count", 64'(err_count), 64'd0);

        // Parity errors: byte 0 parity bit, then data bit 63
        send(64'h0123_4567_89AB_CDEF, 72'h1 << 64, 8'h01);
        send(64'hFEDC_BA98_7654_3210, 72'h1 << 63, 8'h80);
        idle(1);
        drain("parity_drain");
        check("parity_err_count", 64'(err_count), PAR_ON ? 64'd2 : 64'd0);

        // Backpressure: 20 words against a stalled consumer
        out_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) send(64'hA5A5_0000_0000_0000 + 64'(i), 72'h0, 8'h00);
                idle(1);
                stream_done = 1'b1;
            end
        join_none
        repeat (30) @(negedge clk);
        #1;
        check("bp_chain_en", 64'(chain_en), 64'd0);
        check("bp_accepted", 64'(accepted), 64'(TB_LENGTH + TB_DEPTH));
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_rx_none", 64'(rx_count), 64'd3);
        out_ready = 1'b1;
        begin
            int n = 0;
            while (!stream_done && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("bp_stream_done", 64'(stream_done), 64'd1);
        drain("bp_drain");
        check("bp_rx_total", 64'(rx_count), 64'd23);

        // Bubbles: alternate valid / invalid
        rx_count = 0;
        for (int i = 0; i < 5; i++) begin
            send(64'h5555_0000_1111_0000 + 64'(i * 3), 72'h0, 8'h00);
            idle(1);
        end
        drain("bubble_drain");
        repeat (5) @(negedge clk);
        check("bubble_rx", 64'(rx_count), 64'd5);

`ifdef PBOX_PARITY_CHECK_EN
        // Saturation of the error counter
        @(negedge clk);
        force dut.err_cnt = 16'hFFFE;
        #1;
        release dut.err_cnt;
        for (int i = 0; i < 3; i++) send(64'h0000_0000_0000_00F0 + 64'(i), 72'h1 << 65, 8'h02);
        idle(1);
        drain("sat_drain");
        check("sat_err_count", 64'(err_count), 64'hFFFF);
`endif

        // Reset mid-stream: 2 buffered, 3 in flight
        out_ready = 1'b0;
        send(64'h1111_1111_1111_1111, 72'h0, 8'h00);
        send(64'h2222_2222_2222_2222, 72'h0, 8'h00);
        idle(10);
        for (int i = 0; i < 3; i++) send(64'h3333_0000_0000_0000 + 64'(i), 72'h0, 8'h00);
        idle(2);
        #1;
        check("mid_out_valid_pre", 64'(out_valid), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_out_valid_rst", 64'(out_valid), 64'd0);
        check("mid_out_data_rst", out_data, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        rx_count = 0;
        repeat (15) @(negedge clk);
        check("mid_no_old", 64'(rx_count), 64'd0);
        send(64'hCAFE_F00D_DEAD_BEEF, 72'h0, 8'h00);
        check_latency("mid_latency");
        drain("mid_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
